// File: rtl/result_spi_tx.sv
// result_spi_tx: SPI mode-0 slave transmit stage for the ALU result.
// Packs {flags Z,C,V,S ; result} into one frame and shifts it out on MISO,
// MSB first, while the master clocks a transaction. SCLK and SS_n are
// oversampled in the clk domain through SYNC_STAGES-deep synchronizers.
// Optional feature: define RESULT_SPI_TX_PARITY_EN to append an even-parity
// bit after the data bits (transfer becomes FRAME_W+1 bits long).
module result_spi_tx #(
    parameter int FRAME_W     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] result_in,
    input  logic [3:0] flags_in,
    input  logic       load,
    input  logic       clr_overrun,
    input  logic       sclk_in,
    input  logic       ss_n_in,
    output logic       miso_out,
    output logic       busy,
    output logic       tx_done,
    output logic       overrun
);

`ifdef RESULT_SPI_TX_PARITY_EN
    localparam int XFER_W = FRAME_W + 1;
`else
    localparam int XFER_W = FRAME_W;
`endif
    localparam int              CNT_W    = $clog2(XFER_W + 1);
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(XFER_W);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        SHIFT,
        DONE
    } state_t;

    state_t               state, state_nxt;
    logic [FRAME_W-1:0]   tx_buf, tx_buf_nxt;
    logic [FRAME_W-1:0]   hold_reg, hold_reg_nxt;
    logic [XFER_W-1:0]    shift_reg, shift_reg_nxt;
    logic                 pending, pending_nxt;
    logic [CNT_W-1:0]     bit_cnt, bit_cnt_nxt;
    logic                 overrun_nxt;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] ss_sync;
    logic                   sclk_prev;
    logic                   ss_prev;
    logic                   sclk_s;
    logic                   ss_s;
    logic                   sclk_rise;
    logic                   sclk_fall;
    logic                   ss_fall;
    logic                   ss_rise;
    logic                   last_rise;

    logic [FRAME_W-1:0]   frame_in;
    logic [XFER_W-1:0]    xfer_word;

    assign frame_in = FRAME_W'({flags_in, result_in});

`ifdef RESULT_SPI_TX_PARITY_EN
    assign xfer_word = {tx_buf, ^tx_buf};
`else
    assign xfer_word = tx_buf;
`endif

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign ss_s      = ss_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;
    assign ss_fall   = ~ss_s & ss_prev;
    assign ss_rise   = ss_s & ~ss_prev;
    assign last_rise = sclk_rise && (bit_cnt == CNT_TERM - 1'b1);

    // Synchronize the master's pins and keep one delayed copy for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk_sync <= '0;
            ss_sync   <= '1;
            sclk_prev <= 1'b0;
            ss_prev   <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_in};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n_in};
            sclk_prev <= sclk_s;
            ss_prev   <= ss_s;
        end
    end

    // State register plus all datapath registers, loaded from the next-state logic
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            tx_buf    <= '0;
            hold_reg  <= '0;
            shift_reg <= '0;
            pending   <= 1'b0;
            bit_cnt   <= '0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_nxt;
            tx_buf    <= tx_buf_nxt;
            hold_reg  <= hold_reg_nxt;
            shift_reg <= shift_reg_nxt;
            pending   <= pending_nxt;
            bit_cnt   <= bit_cnt_nxt;
            overrun   <= overrun_nxt;
        end
    end

    // Next-state and datapath update; a load always wins over the abort reload
    // and a setting event always wins over clr_overrun
    always_comb begin
        state_nxt     = state;
        tx_buf_nxt    = tx_buf;
        hold_reg_nxt  = hold_reg;
        shift_reg_nxt = shift_reg;
        pending_nxt   = pending;
        bit_cnt_nxt   = bit_cnt;
        overrun_nxt   = overrun;

        if (clr_overrun) begin
            overrun_nxt = 1'b0;
        end

        case (state)
            IDLE: begin
                if (ss_fall) begin
                    shift_reg_nxt = '0;
                    bit_cnt_nxt   = '0;
                end
                if (load) begin
                    tx_buf_nxt  = frame_in;
                    pending_nxt = 1'b1;
                    state_nxt   = ARMED;
                end
            end
            ARMED: begin
                if (ss_fall) begin
                    shift_reg_nxt = xfer_word;
                    hold_reg_nxt  = tx_buf;
                    pending_nxt   = 1'b0;
                    bit_cnt_nxt   = '0;
                    state_nxt     = SHIFT;
                end
                if (load) begin
                    tx_buf_nxt  = frame_in;
                    pending_nxt = 1'b1;
                end
            end
            SHIFT: begin
                if (ss_rise && !last_rise) begin
                    bit_cnt_nxt = '0;
                    state_nxt   = ARMED;
                    if (!pending) begin
                        tx_buf_nxt  = hold_reg;
                        pending_nxt = 1'b1;
                    end
                end else if (sclk_rise) begin
                    bit_cnt_nxt = bit_cnt + 1'b1;
                    if (last_rise) begin
                        state_nxt = DONE;
                    end
                end else if (sclk_fall) begin
                    shift_reg_nxt = {shift_reg[XFER_W-2:0], 1'b0};
                end
                if (load) begin
                    if (pending) begin
                        overrun_nxt = 1'b1;
                    end
                    tx_buf_nxt  = frame_in;
                    pending_nxt = 1'b1;
                end
            end
            DONE: begin
                bit_cnt_nxt = '0;
                state_nxt   = (pending || load) ? ARMED : IDLE;
                if (load) begin
                    if (pending) begin
                        overrun_nxt = 1'b1;
                    end
                    tx_buf_nxt  = frame_in;
                    pending_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign miso_out = ~ss_prev & shift_reg[XFER_W-1];
    assign busy     = (state == SHIFT);
    assign tx_done  = (state == DONE);

endmodule
